// File: rtl/bcd_to_binary_if.sv
// rtl/bcd_to_binary_if.sv - start/busy/done handshake bundle for the BCD-to-binary converter
//
// Purpose: groups the request side (start, bcd_in) and the result side
// (busy, done, bin_out, err) of bcd_to_binary into one port.
// Ports (modport view):
//   master : drives start, bcd_in; observes busy, done, bin_out, err
//   slave  : observes start, bcd_in; drives busy, done, bin_out, err
interface bcd_to_binary_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  done,
    input  bin_out,
    input  err
  );

  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output done,
    output bin_out,
    output err
  );
endinterface

// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - sequential packed-BCD to unsigned binary converter, one digit per clock
//
// Purpose: converts a DIGITS-digit packed BCD word to binary, most significant
// digit first, using acc = acc*10 + d each cycle. A digit above 9 aborts the
// conversion and reports err with a zero result.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : bcd_to_binary_if.slave
//          start   - request, honoured only while busy=0 (IDLE or DONE)
//          bcd_in  - operand, latched on the accepting edge
//          busy    - high while digits are being processed
//          done    - one-cycle pulse, bin_out/err valid in that cycle
//          bin_out - result, held from one done to the next
//          err     - invalid digit seen in the last conversion, held with bin_out
module bcd_to_binary #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  bcd_to_binary_if.slave   bus
);

  localparam int W     = 4 * DIGITS;
  // Counter only needs to reach DIGITS-1; keep at least one bit for DIGITS=1.
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t           state;
  logic [W-1:0]     sr;
  logic [BIN_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             busy_r;
  logic             done_r;
  logic [BIN_W-1:0] bin_r;
  logic             err_r;

  logic [3:0]       digit;
  logic             digit_bad;
  logic [BIN_W-1:0] acc_next;

  // Top nibble of the shift register is always the next digit to consume.
  always_comb begin
    digit     = sr[W-1 -: 4];
    digit_bad = (digit > 4'd9);
    // acc*10 as (acc<<3)+(acc<<1). Working at BIN_W bits gives the same
    // low BIN_W bits as a wider sum followed by truncation, since addition
    // and left shifts only carry upward.
    acc_next  = (acc << 3) + (acc << 1) + BIN_W'(digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sr     <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      bin_r  <= '0;
      err_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state  <= CONV;
            sr     <= bus.bcd_in;
            acc    <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
          end
        end

        CONV: begin
          if (digit_bad) begin
            // Abort: remaining digits are never examined.
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            bin_r  <= '0;
            err_r  <= 1'b1;
          end else begin
            acc <= acc_next;
            sr  <= sr << 4;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              bin_r  <= acc_next;
              err_r  <= 1'b0;
            end
          end
        end

        DONE: begin
          done_r <= 1'b0;
          // busy is already low here, so a new request is taken straight
          // into CONV with no idle gap between conversions.
          if (bus.start) begin
            state  <= CONV;
            sr     <= bus.bcd_in;
            acc    <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.bin_out = bin_r;
  assign bus.err     = err_r;

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential converter from packed BCD to unsigned binary: the inverse of the team's binary-to-BCD display path. It takes score or setting values entered or stored as decimal digits and turns them into binary for arithmetic and comparison. It processes one digit per clock, most significant first, with a start/busy/done handshake. Invalid digits (values above 9) are detected and flagged.

## Interface
- DIGITS, 3, number of BCD digits in the input word; must be at least 1.
- BIN_W, 10, binary output width; 10^DIGITS − 1 must fit in BIN_W bits.
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  reset; synchronous and active-high.
- start  input  1  conversion request; sampled only when busy=0.
- bcd_in  input  4*DIGITS  packed BCD operand; bits [4*DIGITS-1 -: 4] hold the most significant digit; latched on the accepting edge.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse; result and err are valid in this cycle.
- bin_out  output  BIN_W  binary result; held from done until the next done.
- err  output  1  high if the last conversion found a digit > 9; held with bin_out.

## Operation
- States:
  - IDLE: waiting for start.
  - CONV: processing digits.
  - DONE: single cycle in which done is asserted.
- IDLE → CONV on start=1.
  - Latch bcd_in into an internal shift register.
  - Clear the accumulator and the digit counter.
- CONV: each cycle, take the top digit d of the shift register.
  - If d ≤ 9: acc ← acc*10 + d, where acc*10 = (acc<<3) + (acc<<1), computed at BIN_W+4 bits and truncated to BIN_W. Then shift the register left 4 bits and increment the counter.
  - If d > 9: abort. Go to DONE with err=1 and bin_out=0. Remaining digits are not examined.
  - After DIGITS valid digits: go to DONE, bin_out ← acc, err ← 0.
- DONE: done=1 for one cycle, then return to IDLE.
  - A start in the DONE cycle is accepted, because busy=0. The next state is then CONV rather than IDLE, so back-to-back conversions have no idle gap.
- start while busy=1 is ignored; bcd_in changes during CONV have no effect.
- Leading zero digits need no special handling; the arithmetic yields the correct value.
- Reset values:
  - state IDLE
  - busy=0, done=0, err=0
  - bin_out=0, accumulator 0, counter 0

## Timing
- Edge 0: start sampled.
- Edges 1..DIGITS: one digit per edge.
  - busy=1 from the cycle after edge 0 through the cycle after edge DIGITS−1.
  - done=1 in the cycle after edge DIGITS.
- Latency, start to done: DIGITS+1 clocks (4 with the defaults).
- Error at digit index k (0 = MSD): done occurs k+2 clocks after start.
- bin_out and err update on the same edge that raises done, and are stable until the next done.
- rst=1 at any edge, including mid-CONV or during DONE:
  - all outputs return to reset values on that edge;
  - no done is issued for the aborted conversion;
  - start is ignored while rst=1.
- Back-to-back throughput: one result every DIGITS+1 clocks.

## Test plan
- Reset, then start with bcd_in=12'h999 → busy high for 3 cycles; done in cycle 4 with bin_out=999 and err=0; values held until the next start.
- bcd_in=12'h042, then 12'h000 → bin_out=42, then bin_out=0; err=0 both times; each done is exactly one cycle wide.
- bcd_in=12'h0A5 → digit 1 is invalid; done 3 clocks after start with err=1 and bin_out=0. A following 12'h105 → bin_out=105 and err clears.
- Start with 12'h123, then pulse start with 12'h777 during busy and change bcd_in mid-conversion → single done with bin_out=123; the second start is ignored.
- Start with 12'h500, assert start with 12'h250 in the DONE cycle → done twice, 4 clocks apart, giving 500 then 250.
- Start with 12'h876, assert rst on the 2nd CONV cycle → no done; busy=0 and bin_out=0 on the next cycle. A subsequent 12'h876 → bin_out=876.
